// File: rtl/axi_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_bank
// Brief    : Control/config/status/IRQ register file behind an AXI-Lite
//            front end; issues core start pulses and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_bank #(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] CFG_RESET  = 32'h0000_0000,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  axi_write_fire,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [3:0]            wr_strb,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ctrl_enable,
    output logic [7:0]            ctrl_mode,
    output logic                  start_pulse,
    output logic [DATA_WIDTH-1:0] cfg0_o,
    output logic [DATA_WIDTH-1:0] cfg1_o,
    output logic [DATA_WIDTH-1:0] cfg2_o,
    output logic [DATA_WIDTH-1:0] cfg3_o,
    input  logic                  core_busy,
    input  logic                  core_done,
    input  logic                  core_err,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STATUS  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CFG0    = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CFG1    = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CFG2    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_CFG3    = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_IRQ_EN  = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_WR_CNT  = ADDR_WIDTH'(7);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_VERSION = ADDR_WIDTH'(8);
    localparam int                    c_NUM_CFG      = 4;

    // Registered state
    logic                  r_ctrl_enable;
    logic [7:0]            r_ctrl_mode;
    logic                  r_start_pulse;
    logic                  r_done;
    logic                  r_err;
    logic                  r_start_rej;
    logic [3:1]            r_irq_en;
    logic [31:0]           r_wr_cnt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] r_cfg [c_NUM_CFG];

    // Decode and next-state
    logic                  w_wr_ctrl;
    logic                  w_wr_status;
    logic                  w_wr_irq_en;
    logic                  w_enable_next;
    logic [7:0]            w_mode_next;
    logic                  w_start_req;
    logic                  w_start_ok;
    logic [3:1]            w_w1c;
    logic                  w_done_next;
    logic                  w_err_next;
    logic                  w_rej_next;
    logic [3:1]            w_irq_en_next;
    logic                  w_irq_next;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [3:0]            strb
    );
        f_merge = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                f_merge[8*b +: 8] = new_v[8*b +: 8];
            end
        end
    endfunction

    assign w_wr_ctrl   = axi_write_fire && (wr_addr == c_ADDR_CTRL);
    assign w_wr_status = axi_write_fire && (wr_addr == c_ADDR_STATUS);
    assign w_wr_irq_en = axi_write_fire && (wr_addr == c_ADDR_IRQ_EN);

    always_comb begin
        w_enable_next = r_ctrl_enable;
        w_mode_next   = r_ctrl_mode;
        w_start_req   = 1'b0;
        if (w_wr_ctrl) begin
            if (wr_strb[0]) begin
                w_enable_next = wr_data[0];
                w_start_req   = wr_data[1];
            end
            if (wr_strb[1]) begin
                w_mode_next = wr_data[15:8];
            end
        end
    end

    // A start is judged against the enable value this same write produces.
    assign w_start_ok = w_start_req && w_enable_next && !core_busy;

    assign w_w1c = (w_wr_status && wr_strb[0]) ? wr_data[3:1] : 3'b000;

    // New events override a simultaneous write-1-to-clear.
    assign w_done_next = core_done || (r_done && !w_w1c[1]);
    assign w_err_next  = core_err  || (r_err  && !w_w1c[2]);
    assign w_rej_next  = (w_start_req && !w_start_ok) || (r_start_rej && !w_w1c[3]);

    assign w_irq_en_next = (w_wr_irq_en && wr_strb[0]) ? wr_data[3:1] : r_irq_en;
    assign w_irq_next    = |({w_rej_next, w_err_next, w_done_next} & w_irq_en_next);

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            c_ADDR_CTRL:    w_rd_mux = {16'h0000, r_ctrl_mode, 6'b000000, 1'b0, r_ctrl_enable};
            c_ADDR_STATUS:  w_rd_mux = {28'h0000000, r_start_rej, r_err, r_done, core_busy};
            c_ADDR_CFG0:    w_rd_mux = r_cfg[0];
            c_ADDR_CFG1:    w_rd_mux = r_cfg[1];
            c_ADDR_CFG2:    w_rd_mux = r_cfg[2];
            c_ADDR_CFG3:    w_rd_mux = r_cfg[3];
            c_ADDR_IRQ_EN:  w_rd_mux = {28'h0000000, r_irq_en, 1'b0};
            c_ADDR_WR_CNT:  w_rd_mux = r_wr_cnt;
            c_ADDR_VERSION: w_rd_mux = VERSION;
            default:        w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_ctrl_enable <= 1'b0;
            r_ctrl_mode   <= 8'h00;
            r_start_pulse <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_start_rej   <= 1'b0;
            r_irq_en      <= 3'b000;
            r_wr_cnt      <= 32'h0000_0000;
            r_rd_data     <= '0;
            r_irq         <= 1'b0;
        end else begin
            r_ctrl_enable <= w_enable_next;
            r_ctrl_mode   <= w_mode_next;
            r_start_pulse <= w_start_ok;
            r_done        <= w_done_next;
            r_err         <= w_err_next;
            r_start_rej   <= w_rej_next;
            r_irq_en      <= w_irq_en_next;
            r_irq         <= w_irq_next;
            if (axi_write_fire) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            // Mux sees pre-write values, so a colliding read returns old data.
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    for (genvar i = 0; i < c_NUM_CFG; i++) begin : g_cfg
        localparam logic [ADDR_WIDTH-1:0] c_ADDR = c_ADDR_CFG0 + ADDR_WIDTH'(i);
        always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
            if (!s_axi_aresetn) begin
                r_cfg[i] <= CFG_RESET;
            end else if (axi_write_fire && (wr_addr == c_ADDR)) begin
                r_cfg[i] <= f_merge(r_cfg[i], wr_data, wr_strb);
            end
        end
    end

    assign rd_data     = r_rd_data;
    assign ctrl_enable = r_ctrl_enable;
    assign ctrl_mode   = r_ctrl_mode;
    assign start_pulse = r_start_pulse;
    assign cfg0_o      = r_cfg[0];
    assign cfg1_o      = r_cfg[1];
    assign cfg2_o      = r_cfg[2];
    assign cfg3_o      = r_cfg[3];
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_bank
// Brief    : Directed self-checking bench for axi_lite_reg_bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_bank;

    localparam int          ADDR_WIDTH = 6;
    localparam logic [31:0] CFG_RESET  = 32'hC0DE_5A5A;
    localparam logic [31:0] VERSION    = 32'h0001_0000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  axi_write_fire = 1'b0;
    logic [ADDR_WIDTH-1:0] wr_addr = '0;
    logic [31:0]           wr_data = '0;
    logic [3:0]            wr_strb = '0;
    logic                  rd_en = 1'b0;
    logic [ADDR_WIDTH-1:0] rd_addr = '0;
    logic [31:0]           rd_data;
    logic                  ctrl_enable;
    logic [7:0]            ctrl_mode;
    logic                  start_pulse;
    logic [31:0]           cfg0_o, cfg1_o, cfg2_o, cfg3_o;
    logic                  core_busy = 1'b0;
    logic                  core_done = 1'b0;
    logic                  core_err = 1'b0;
    logic                  irq;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] m_wr_cnt = 32'd0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    axi_lite_reg_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (32),
        .CFG_RESET  (CFG_RESET),
        .VERSION    (VERSION)
    ) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .axi_write_fire (axi_write_fire),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_strb        (wr_strb),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .ctrl_enable    (ctrl_enable),
        .ctrl_mode      (ctrl_mode),
        .start_pulse    (start_pulse),
        .cfg0_o         (cfg0_o),
        .cfg1_o         (cfg1_o),
        .cfg2_o         (cfg2_o),
        .cfg3_o         (cfg3_o),
        .core_busy      (core_busy),
        .core_done      (core_done),
        .core_err       (core_err),
        .irq            (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle launched just after a falling edge; returns on the next one.
    task automatic bus(input bit do_wr, input logic [ADDR_WIDTH-1:0] waddr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input bit do_rd, input logic [ADDR_WIDTH-1:0] raddr,
                       input logic [31:0] rexp, input string tag);
        axi_write_fire = do_wr;
        wr_addr        = waddr;
        wr_data        = wdata;
        wr_strb        = strb;
        rd_en          = do_rd;
        rd_addr        = raddr;
        if (do_wr) m_wr_cnt = m_wr_cnt + 32'd1;
        if (do_rd) begin
            exp_q.push_back(rexp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        axi_write_fire = 1'b0;
        rd_en          = 1'b0;
        if (do_rd) chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
    endtask

    task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(1'b1, a, d, s, 1'b0, '0, '0, "");
    endtask

    task automatic rd(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] e, input string tag);
        bus(1'b0, '0, '0, '0, 1'b1, a, e, tag);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_start", {31'b0, start_pulse}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_ctrl", {23'b0, ctrl_mode, ctrl_enable}, 32'h0);
        chk("rst_cfg0", cfg0_o, CFG_RESET);
        rst_n = 1'b1;
        @(negedge clk);

        rd(6'h02, CFG_RESET, "rd_cfg0_reset");
        rd(6'h07, 32'h0, "rd_wrcnt_reset");
        rd(6'h08, VERSION, "rd_version");

        wr(6'h03, 32'hAABB_CCDD, 4'b1111);
        wr(6'h03, 32'h1122_3344, 4'b0101);
        rd(6'h03, 32'hAA22_CC44, "rd_cfg1_strb");
        chk("cfg1_o", cfg1_o, 32'hAA22_CC44);
        rd(6'h07, m_wr_cnt, "rd_wrcnt_2");

        core_busy = 1'b0;
        wr(6'h00, 32'h0000_0503, 4'b1111);
        chk("start_hi", {31'b0, start_pulse}, 32'h1);
        @(negedge clk);
        chk("start_lo", {31'b0, start_pulse}, 32'h0);
        chk("ctrl_mode", {24'b0, ctrl_mode}, 32'h05);
        chk("ctrl_enable", {31'b0, ctrl_enable}, 32'h1);
        rd(6'h00, 32'h0000_0501, "rd_ctrl");

        core_busy = 1'b1;
        wr(6'h00, 32'h0000_0503, 4'b1111);
        chk("start_busy_a", {31'b0, start_pulse}, 32'h0);
        @(negedge clk);
        chk("start_busy_b", {31'b0, start_pulse}, 32'h0);
        rd(6'h01, 32'h9, "rd_status_rej");
        wr(6'h01, 32'h8, 4'b1111);
        rd(6'h01, 32'h1, "rd_status_w1c");
        core_busy = 1'b0;
        rd(6'h01, 32'h0, "rd_status_idle");

        wr(6'h06, 32'hFFFF_FFF2 & 32'h2, 4'b1111);
        rd(6'h06, 32'h2, "rd_irq_en");
        chk("irq_idle", {31'b0, irq}, 32'h0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("irq_done", {31'b0, irq}, 32'h1);
        core_done = 1'b1;
        wr(6'h01, 32'h2, 4'b1111);
        core_done = 1'b0;
        chk("irq_set_wins", {31'b0, irq}, 32'h1);
        rd(6'h01, 32'h2, "rd_status_set_wins");
        wr(6'h01, 32'h2, 4'b1111);
        chk("irq_cleared", {31'b0, irq}, 32'h0);
        rd(6'h01, 32'h0, "rd_status_clean");

        bus(1'b1, 6'h02, 32'hDEAD_BEEF, 4'b1111, 1'b1, 6'h02, CFG_RESET, "rd_collide_old");
        rd(6'h02, 32'hDEAD_BEEF, "rd_cfg0_new");

        wr(6'h3F, 32'hFFFF_FFFF, 4'b1111);
        rd(6'h3F, 32'h0, "rd_unmapped");
        wr(6'h04, 32'h1234_5678, 4'b0000);
        rd(6'h04, CFG_RESET, "rd_strb_zero");
        rd(6'h07, m_wr_cnt, "rd_wrcnt_final");

        core_done = 1'b1;
        bus(1'b1, 6'h00, 32'h0000_0001 | 32'h2, 4'b1111, 1'b1, 6'h08, VERSION, "rd_version_pre_rst");
        core_done = 1'b0;
        chk("pre_rst_start", {31'b0, start_pulse}, 32'h1);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_data", rd_data, 32'h0);
        chk("mid_rst_start", {31'b0, start_pulse}, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_ctrl", {23'b0, ctrl_mode, ctrl_enable}, 32'h0);
        chk("mid_rst_cfg0", cfg0_o, CFG_RESET);
        @(negedge clk);
        rst_n = 1'b1;
        m_wr_cnt = 32'd0;
        @(negedge clk);
        rd(6'h07, m_wr_cnt, "rd_wrcnt_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
